// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Four-state debouncer for a mechanical switch. The level moves
//               only after the sample holds the new value for 2^N+1 edges;
//               db_tick pulses once per debounced rising transition.
//               Optional macro SWITCH_DEBOUNCER_SYNC_EN adds a two-flop
//               input synchronizer (2 cycles extra latency).
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int N = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    // Bit 1 of the encoding is the debounced level, so db_level is a single
    // flop output and cannot glitch.
    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b11,
        WAIT0 = 2'b10
    } state_t;

    localparam logic [N-1:0] c_CNT_MAX  = {N{1'b1}};
    localparam logic [N-1:0] c_CNT_ZERO = '0;
    localparam logic [N-1:0] c_CNT_STEP = N'(1);

    state_t         r_state;
    logic [N-1:0]   r_cnt;
    logic           r_tick;
    logic           w_s;

`ifdef SWITCH_DEBOUNCER_SYNC_EN
    logic r_sync_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
        end else begin
            r_sync_meta <= sw;
            r_sync      <= r_sync_meta;
        end
    end

    assign w_s = r_sync;
`else
    assign w_s = sw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ZERO;
            r_cnt   <= c_CNT_ZERO;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ZERO: begin
                    if (w_s) begin
                        r_state <= WAIT1;
                        r_cnt   <= c_CNT_MAX;
                    end
                end
                WAIT1: begin
                    if (!w_s) begin
                        r_state <= ZERO;
                    end else if (r_cnt == c_CNT_ZERO) begin
                        r_state <= ONE;
                        r_tick  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_STEP;
                    end
                end
                ONE: begin
                    if (!w_s) begin
                        r_state <= WAIT0;
                        r_cnt   <= c_CNT_MAX;
                    end
                end
                WAIT0: begin
                    // Returning to ONE here is a glitch, not a new rise: no tick.
                    if (w_s) begin
                        r_state <= ONE;
                    end else if (r_cnt == c_CNT_ZERO) begin
                        r_state <= ZERO;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_STEP;
                    end
                end
                default: begin
                    r_state <= ZERO;
                end
            endcase
        end
    end

    assign db_level = r_state[1];
    assign db_tick  = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_debouncer
// Description : Self-checking bench for switch_debouncer (N=3, window 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_debouncer;

    localparam int N   = 3;
    localparam int WIN = 1 << N;
`ifdef SWITCH_DEBOUNCER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int EDGES = WIN + 1 + LAT;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic sw    = 1'b0;
    logic db_level;
    logic db_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: level flips once the sample has differed from it for
    // WIN+1 consecutive edges; sync latency is a plain delay line.
    bit m_level;
    bit m_tick;
    int m_run;
    bit m_pipe[$];

    typedef struct {
        bit sw;
        int cycles;
        bit exp_level;
        int exp_ticks;
    } seg_t;

    seg_t segs[8];

    switch_debouncer #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_level = 1'b0;
        m_tick  = 1'b0;
        m_run   = 0;
        m_pipe.delete();
        for (int i = 0; i < LAT; i++) m_pipe.push_back(1'b0);
    endfunction

    function automatic void model_edge(input bit sw_now);
        bit s;
        if (LAT == 0) begin
            s = sw_now;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(sw_now);
        end
        m_tick = 1'b0;
        if (s != m_level) m_run++;
        else              m_run = 0;
        if (m_run == WIN + 1) begin
            m_level = s;
            m_run   = 0;
            m_tick  = s;
        end
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (!reset) model_edge(sw);
        #1;
        check({tag, " level"}, db_level, m_level);
        check({tag, " tick"},  db_tick,  m_tick);
    endtask

    task automatic pulse_reset(input int cycles);
        #2 reset = 1'b1;
        #1 model_reset();
        check("reset level", db_level, 1'b0);
        check("reset tick",  db_tick,  1'b0);
        repeat (cycles) step("in reset");
        #2 reset = 1'b0;
    endtask

    // Counts edges until db_level reaches target; 0 means it never did.
    task automatic edges_until(input logic target, input string tag, output int at, output int ticks);
        at    = 0;
        ticks = 0;
        for (int e = 1; e <= 40; e++) begin
            step(tag);
            ticks += int'(db_tick);
            if (db_level == target) begin
                at = e;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int at;
        int ticks;
        int len;
        int toggles;
        bit cur;

        segs[0] = '{sw: 1'b0, cycles: 5,  exp_level: 1'b0, exp_ticks: 0};
        segs[1] = '{sw: 1'b1, cycles: 5,  exp_level: 1'b0, exp_ticks: 0};
        segs[2] = '{sw: 1'b0, cycles: 1,  exp_level: 1'b0, exp_ticks: 0};
        segs[3] = '{sw: 1'b1, cycles: 12, exp_level: 1'b1, exp_ticks: 1};
        segs[4] = '{sw: 1'b0, cycles: 4,  exp_level: 1'b1, exp_ticks: 0};
        segs[5] = '{sw: 1'b1, cycles: 12, exp_level: 1'b1, exp_ticks: 0};
        segs[6] = '{sw: 1'b0, cycles: 12, exp_level: 1'b0, exp_ticks: 0};
        segs[7] = '{sw: 1'b1, cycles: 20, exp_level: 1'b1, exp_ticks: 1};

        model_reset();
        pulse_reset(3);

        // Table-driven segments
        for (int i = 0; i < 8; i++) begin
            ticks = 0;
            sw = segs[i].sw;
            repeat (segs[i].cycles) begin
                step("seg");
                ticks += int'(db_tick);
            end
            check("seg end level", db_level, segs[i].exp_level);
            check_int("seg tick count", ticks, segs[i].exp_ticks);
        end

        // Clean rise: exact latency and single-cycle tick
        sw = 1'b0;
        repeat (15) step("settle0");
        sw = 1'b1;
        edges_until(1'b1, "rise", at, ticks);
        check_int("rise latency", at, EDGES);
        check("rise tick on first level cycle", db_tick, 1'b1);
        step("rise+1");
        check("rise tick cleared", db_tick, 1'b0);
        ticks = 0;
        repeat (20) begin
            step("hold1");
            ticks += int'(db_tick);
        end
        check_int("no extra ticks while held", ticks, 0);

        // Fall with a one-cycle glitch at cycle 4 restarting the count
        sw = 1'b0;
        repeat (3) step("fall pre");
        sw = 1'b1;
        step("fall glitch");
        sw = 1'b0;
        edges_until(1'b0, "fall", at, ticks);
        check_int("fall latency after glitch", at, EDGES);
        check_int("no tick on fall", ticks, 0);

        // Reset mid-qualification with sw held high
        sw = 1'b1;
        repeat (4) step("wait1 part");
        pulse_reset(3);
        edges_until(1'b1, "post-reset rise", at, ticks);
        check_int("rise latency after reset", at, EDGES);
        check_int("tick after reset rise", ticks, 1);

        // Reset while in ONE
        repeat (3) step("one");
        pulse_reset(2);
        edges_until(1'b1, "post-reset rise2", at, ticks);
        check_int("rise latency after reset in ONE", at, EDGES);

        // Bounce of 1..7 cycle pulses, then stable high
        sw = 1'b0;
        repeat (15) step("settle0b");
        cur     = 1'b1;
        len     = 0;
        toggles = 0;
        while (len < 50) begin
            int plen;
            plen = int'($urandom_range(1, 7));
            sw = cur;
            repeat (plen) begin
                step("bounce");
                if (db_level !== 1'b0) toggles++;
            end
            len += plen;
            cur = ~cur;
        end
        check_int("level moved during bounce", toggles, 0);
        sw = 1'b1;
        ticks = 0;
        repeat (30) begin
            step("after bounce");
            ticks += int'(db_tick);
        end
        check_int("ticks after bounce", ticks, 1);
        check("level after bounce", db_level, 1'b1);

        // Randomized run against the reference model
        for (int r = 0; r < 300; r++) begin
            sw = 1'(($urandom() >> 3) & 1);
            repeat (int'($urandom_range(1, 14))) step("random");
            if ($urandom_range(0, 40) == 0) pulse_reset(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter N, default 20, counter width; the stability window is 2^N clock cycles (about 10.5 ms at 100 MHz).
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 sw  input  1  raw mechanical switch level; asynchronous and bouncing.
REQ-005 db_level  output  1  debounced level; the downstream edge detector consumes it as its level input.
REQ-006 db_tick  output  1  registered one-cycle pulse marking each debounced 0->1 transition.

Function
REQ-007 Internal sample s SHALL be sw passed through the input stage defined in REQ-020/REQ-021.
REQ-008 The FSM SHALL have exactly four states: ZERO, WAIT1, ONE, WAIT0. A down-counter cnt is N bits wide.
REQ-009 ZERO: db_level=0; if s=1, go to WAIT1 and load cnt=2^N-1; otherwise stay.
REQ-010 WAIT1: db_level=0; if s=0, go to ZERO (partial count discarded); if s=1 and cnt=0, go to ONE; if s=1 and cnt!=0, decrement cnt.
REQ-011 ONE: db_level=1; if s=0, go to WAIT0 and load cnt=2^N-1; otherwise stay.
REQ-012 WAIT0: db_level=1; if s=1, go to ONE (partial count discarded); if s=0 and cnt=0, go to ZERO; if s=0 and cnt!=0, decrement cnt.
REQ-013 db_level SHALL be decoded from the state register only (1 in ONE/WAIT0) and SHALL be glitch-free.
REQ-014 db_level SHALL change only after s has held the new value at 2^N+1 consecutive rising edges. The first edge enters the WAIT state; db_level changes after the (2^N+1)-th edge.
REQ-015 Any single-cycle opposite sample inside a WAIT state SHALL restart qualification from the beginning; no count is retained.
REQ-016 db_tick SHALL be 1 in exactly the first cycle db_level is 1 after a WAIT1->ONE transition, and 0 otherwise. It is never asserted on WAIT0->ONE or on falling transitions.
REQ-017 cnt SHALL never wrap: no decrement occurs at cnt=0, and cnt is reloaded only on ZERO->WAIT1 and ONE->WAIT0.

Reset
REQ-018 Reset SHALL asynchronously force state=ZERO, cnt=0, db_level=0, db_tick=0, and clear all synchronizer flops.
REQ-019 Reset asserted mid-qualification (WAIT1/WAIT0) SHALL abandon the count. After release, operation restarts from ZERO, and a held sw=1 requires a full new window.

Configuration
REQ-020 With macro SWITCH_DEBOUNCER_SYNC_EN defined, s SHALL be sw through a two-flop synchronizer, adding exactly 2 cycles of latency to REQ-014.
REQ-021 Without SWITCH_DEBOUNCER_SYNC_EN, s SHALL equal sw sampled directly by the FSM; the caller guarantees sw is synchronous to clk.

Verification (N=3, window 8; latencies quoted without SYNC_EN, +2 with it)
REQ-022 Reset pulse mid-run with sw=1 held -> db_level=0 and db_tick=0 immediately; db_level rises 9 edges after reset release.
REQ-023 Clean sw 0->1 held -> WAIT1 at edge k, db_level=1 after edge k+8, db_tick=1 for that single cycle only.
REQ-024 sw=1 for 5 cycles, 0 for 1 cycle, then 1 held -> no rise during the first burst; db_level rises 9 edges after the final 0->1.
REQ-025 From ONE, sw 1->0 held -> db_level=0 after 9 edges, no db_tick; a 1-cycle sw=1 glitch at cycle 4 returns to ONE and restarts the count.
REQ-026 Random bounce of 1-7 cycle pulses for 50 cycles, then stable 1 -> exactly one db_tick, and db_level never toggles during the bounce.
REQ-027 SYNC_EN build, repeat REQ-023 -> db_level rises after edge k+10; the cnt=0 boundary holds with no wrap (cnt never reads 7 after 0 without a reload).
